packet_injector: RTL and testbench

- Transmit-side counterpart of the arbiter's packet tracking logic.
- Accepts one whole packet (destination plus payload words) through a load handshake and buffers it.
- Serializes the packet onto the NOC link as PKT_FLITS flits, one per accepted cycle, using a valid/ready handshake. The first flit is the head, the last flit is the tail.
- Sits at each node's network-interface injection port, upstream of the router/arbiter input.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/inj_flit_counter.sv | 47 ++++
 rtl/noc_dff.sv | 21 ++
 rtl/packet_injector.sv | 144 ++++++++++++++
 tb/tb_packet_injector.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NOC definitions used by both the injector and the arbiter-side
// packet tracker so that both ends agree on packet length and flit layout.
package noc_pkg;

    localparam int unsigned FLIT_WIDTH_DEFAULT = 8;
    localparam int unsigned DEST_WIDTH_DEFAULT = 4;
    localparam int unsigned PKT_FLITS_DEFAULT  = 5;

    // Flit indices inside a packet: index 0 is the head, the last is the tail.
    localparam int unsigned HEAD_IDX = 0;
    localparam int unsigned TAIL_IDX = PKT_FLITS_DEFAULT - 1;

    typedef logic [FLIT_WIDTH_DEFAULT-1:0] flit_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } inj_state_t;

endpackage

// File: rtl/inj_flit_counter.sv
// Flit position counter for the packet injector. Counts 0..LAST and wraps
// back to 0 only from LAST, so unused codes are never visited. clr wins
// over inc.
module inj_flit_counter
    import noc_pkg::*;
#(
    parameter int unsigned CNT_W = $clog2(PKT_FLITS_DEFAULT),
    parameter int unsigned LAST  = TAIL_IDX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_tail
);

    logic [CNT_W-1:0] count_nxt_s;

    assign at_tail = (count == CNT_W'(LAST));

    // Next-count selection: clear, advance (wrapping from LAST), or hold.
    always_comb begin
        count_nxt_s = count;
        if (clr) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else if (inc) begin
            if (at_tail) begin
                count_nxt_s = {CNT_W{1'b0}};
            end else begin
                count_nxt_s = count + CNT_W'(1);
            end
        end else begin
            count_nxt_s = count;
        end
    end

    noc_dff #(
        .W (CNT_W)
    ) u_count_ff (
        .clk   (clk),
        .reset (reset),
        .d     (count_nxt_s),
        .q     (count)
    );

endmodule

// File: rtl/noc_dff.sv
// Plain D flop with synchronous active-high reset to zero; the building
// block for small state registers in the NOC interface logic.
module noc_dff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d on each rising edge, clearing on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= {W{1'b0}};
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/packet_injector.sv
// Packet injector: buffers one packet (destination + payload words) taken
// through a load handshake and serializes it onto the NOC link as
// PKT_FLITS flits (head first, tail last) under valid/ready flow control.
// All link-side outputs are registered, so they hold steady during stalls.
// Optional feature macro: PACKET_INJECTOR_PARITY_EN adds a registered
// even-parity bit per flit; without it flit_parity_o is tied low.
module packet_injector
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FLIT_WIDTH_DEFAULT,
    parameter int unsigned DEST_WIDTH = DEST_WIDTH_DEFAULT,
    parameter int unsigned PKT_FLITS  = PKT_FLITS_DEFAULT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pkt_valid_i,
    output logic                              pkt_ready_o,
    input  logic [DEST_WIDTH-1:0]             pkt_dest_i,
    input  logic [(PKT_FLITS-1)*DATA_WIDTH-1:0] pkt_payload_i,
    output logic                              flit_valid_o,
    input  logic                              flit_ready_i,
    output logic [DATA_WIDTH-1:0]             flit_data_o,
    output logic                              flit_head_o,
    output logic                              flit_tail_o,
    output logic                              pkt_sent_o,
    output logic                              flit_parity_o
);

    localparam int unsigned CNT_W = $clog2(PKT_FLITS);
    localparam int unsigned PAY_W = (PKT_FLITS - 1) * DATA_WIDTH;

    inj_state_t         state_r;
    logic [PAY_W-1:0]   payload_r;
    logic [CNT_W-1:0]   count_s;
    logic               at_tail_s;
    logic               load_s;
    logic               xfer_s;
    logic               inc_s;
    logic               clr_s;
    logic               next_tail_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic [DATA_WIDTH-1:0] next_word_s;

    // Handshake decode and next-flit selection. While showing flit k
    // (k = count), the flit that follows is payload word k.
    always_comb begin
        load_s      = pkt_valid_i & pkt_ready_o;
        xfer_s      = flit_valid_o & flit_ready_i;
        inc_s       = xfer_s & ~at_tail_s;
        clr_s       = load_s | (xfer_s & at_tail_s);
        head_data_s = DATA_WIDTH'(pkt_dest_i);
        next_word_s = payload_r[32'(count_s) * DATA_WIDTH +: DATA_WIDTH];
        next_tail_s = (count_s == CNT_W'(PKT_FLITS - 2));
    end

    inj_flit_counter #(
        .CNT_W (CNT_W),
        .LAST  (PKT_FLITS - 1)
    ) u_flit_counter (
        .clk     (clk),
        .reset   (reset),
        .inc     (inc_s),
        .clr     (clr_s),
        .count   (count_s),
        .at_tail (at_tail_s)
    );

    // Injector FSM with registered link and load-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            payload_r    <= {PAY_W{1'b0}};
            pkt_ready_o  <= 1'b1;
            flit_valid_o <= 1'b0;
            flit_data_o  <= {DATA_WIDTH{1'b0}};
            flit_head_o  <= 1'b0;
            flit_tail_o  <= 1'b0;
            pkt_sent_o   <= 1'b0;
        end else begin
            pkt_sent_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        state_r      <= SEND;
                        payload_r    <= pkt_payload_i;
                        pkt_ready_o  <= 1'b0;
                        flit_valid_o <= 1'b1;
                        flit_data_o  <= head_data_s;
                        flit_head_o  <= 1'b1;
                        flit_tail_o  <= 1'b0;
                    end
                end
                SEND: begin
                    if (xfer_s) begin
                        if (at_tail_s) begin
                            state_r      <= IDLE;
                            pkt_ready_o  <= 1'b1;
                            flit_valid_o <= 1'b0;
                            flit_data_o  <= {DATA_WIDTH{1'b0}};
                            flit_head_o  <= 1'b0;
                            flit_tail_o  <= 1'b0;
                            pkt_sent_o   <= 1'b1;
                        end else begin
                            flit_data_o  <= next_word_s;
                            flit_head_o  <= 1'b0;
                            flit_tail_o  <= next_tail_s;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    pkt_ready_o  <= 1'b1;
                    flit_valid_o <= 1'b0;
                    flit_data_o  <= {DATA_WIDTH{1'b0}};
                    flit_head_o  <= 1'b0;
                    flit_tail_o  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PACKET_INJECTOR_PARITY_EN
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    // Parity register loaded in step with flit_data_o so it tracks the
    // flit through stalls and drops to 0 whenever the link is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            flit_parity_o <= 1'b0;
        end else if ((state_r == IDLE) && load_s) begin
            flit_parity_o <= even_parity(head_data_s);
        end else if ((state_r == SEND) && xfer_s) begin
            flit_parity_o <= at_tail_s ? 1'b0 : even_parity(next_word_s);
        end else begin
            flit_parity_o <= flit_parity_o;
        end
    end
`else
    assign flit_parity_o = 1'b0;
`endif

endmodule

// File: tb/tb_packet_injector.sv
// Directed bench for packet_injector at default parameters (8-bit flits,
// 4-bit destination, 5 flits per packet). Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_packet_injector;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pkt_valid_i;
    logic        pkt_ready_o;
    logic [3:0]  pkt_dest_i;
    logic [31:0] pkt_payload_i;
    logic        flit_valid_o;
    logic        flit_ready_i;
    logic [7:0]  flit_data_o;
    logic        flit_head_o;
    logic        flit_tail_o;
    logic        pkt_sent_o;
    logic        flit_parity_o;

    int checks = 0;
    int errors = 0;

    // Downstream packet tracker model.
    int   trk_cnt = 0;
    int   trk_len = 0;
    logic trk_bad = 1'b0;

    packet_injector dut (
        .clk           (clk),
        .reset         (reset),
        .pkt_valid_i   (pkt_valid_i),
        .pkt_ready_o   (pkt_ready_o),
        .pkt_dest_i    (pkt_dest_i),
        .pkt_payload_i (pkt_payload_i),
        .flit_valid_o  (flit_valid_o),
        .flit_ready_i  (flit_ready_i),
        .flit_data_o   (flit_data_o),
        .flit_head_o   (flit_head_o),
        .flit_tail_o   (flit_tail_o),
        .pkt_sent_o    (pkt_sent_o),
        .flit_parity_o (flit_parity_o)
    );

    always #5 clk = ~clk;

    // Count flits per packet as the arbiter-side tracker would.
    always @(posedge clk) begin
        if (reset) begin
            trk_cnt <= 0;
            trk_len <= 0;
        end else if (flit_valid_o && flit_ready_i) begin
            if (flit_head_o != (trk_cnt == 0)) trk_bad <= 1'b1;
            if (flit_tail_o) begin
                trk_len <= trk_cnt + 1;
                trk_cnt <= 0;
            end else begin
                trk_cnt <= trk_cnt + 1;
                if (flit_head_o) trk_len <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_parity(input flit_t d);
`ifdef PACKET_INJECTOR_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {31'd0, flit_valid_o}, 32'd0);
        check({tag, "_ready"}, {31'd0, pkt_ready_o}, 32'd1);
        check({tag, "_data"}, {24'd0, flit_data_o}, 32'd0);
        check({tag, "_head"}, {31'd0, flit_head_o}, 32'd0);
        check({tag, "_tail"}, {31'd0, flit_tail_o}, 32'd0);
        check({tag, "_parity"}, {31'd0, flit_parity_o}, 32'd0);
    endtask

    task automatic load_pkt(input logic [3:0] dest, input logic [31:0] payload);
        pkt_dest_i    = dest;
        pkt_payload_i = payload;
        pkt_valid_i   = 1'b1;
        check("load_ready", {31'd0, pkt_ready_o}, 32'd1);
        tick();
        pkt_valid_i = 1'b0;
    endtask

    // Starts in the cycle the head flit is shown; ends in the cycle after
    // the tail transfer.
    task automatic expect_pkt(input logic [3:0] dest, input logic [31:0] payload,
                              input int stall_idx, input int stall_len);
        flit_t exp_d;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) exp_d = {4'h0, dest};
            else        exp_d = payload[(i-1)*8 +: 8];
            if (i == stall_idx) begin
                flit_ready_i = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_valid", {31'd0, flit_valid_o}, 32'd1);
                    check("stall_data", {24'd0, flit_data_o}, {24'd0, exp_d});
                    check("stall_head", {31'd0, flit_head_o}, {31'd0, (i == int'(HEAD_IDX))});
                    check("stall_tail", {31'd0, flit_tail_o}, {31'd0, (i == int'(TAIL_IDX))});
                    check("stall_sent", {31'd0, pkt_sent_o}, 32'd0);
                    tick();
                end
                flit_ready_i = 1'b1;
            end
            check("flit_valid", {31'd0, flit_valid_o}, 32'd1);
            check("flit_data", {24'd0, flit_data_o}, {24'd0, exp_d});
            check("flit_head", {31'd0, flit_head_o}, {31'd0, (i == int'(HEAD_IDX))});
            check("flit_tail", {31'd0, flit_tail_o}, {31'd0, (i == int'(TAIL_IDX))});
            check("flit_parity", {31'd0, flit_parity_o}, {31'd0, exp_parity(exp_d)});
            check("busy_ready", {31'd0, pkt_ready_o}, 32'd0);
            check("early_sent", {31'd0, pkt_sent_o}, 32'd0);
            tick();
        end
        check("sent_pulse", {31'd0, pkt_sent_o}, 32'd1);
        check_idle("post_tail");
        check("trk_len", trk_len, 32'd5);
    endtask

    initial begin
        logic [3:0]  rd;
        logic [31:0] rp;
        int          sidx;
        int          slen;

        reset         = 1'b1;
        pkt_valid_i   = 1'b0;
        pkt_dest_i    = 4'h0;
        pkt_payload_i = 32'h0;
        flit_ready_i  = 1'b1;
        tick();
        tick();
        check_idle("rst");
        check("rst_sent", {31'd0, pkt_sent_o}, 32'd0);
        check("rst_count", {29'd0, dut.count_s}, 32'd0);
        reset = 1'b0;
        tick();
        check_idle("idle");

        // Basic packet, full throughput.
        load_pkt(4'h3, 32'h44332211);
        expect_pkt(4'h3, 32'h44332211, -1, 0);
        tick();
        check("sent_once", {31'd0, pkt_sent_o}, 32'd0);

        // Three-cycle stall while flit 0x22 is shown.
        load_pkt(4'h3, 32'h44332211);
        expect_pkt(4'h3, 32'h44332211, 2, 3);
        tick();

        // Second packet offered throughout the first one.
        load_pkt(4'h3, 32'h44332211);
        pkt_valid_i   = 1'b1;
        pkt_dest_i    = 4'hA;
        pkt_payload_i = 32'hDDCCBBAA;
        expect_pkt(4'h3, 32'h44332211, -1, 0);
        tick();
        pkt_valid_i = 1'b0;
        expect_pkt(4'hA, 32'hDDCCBBAA, -1, 0);
        tick();

        // Reset while the third flit is shown.
        load_pkt(4'h5, 32'h0F0E0D0C);
        tick();
        tick();
        check("third_flit", {24'd0, flit_data_o}, 32'h0D);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("midrst");
        check("midrst_sent", {31'd0, pkt_sent_o}, 32'd0);
        check("midrst_count", {29'd0, dut.count_s}, 32'd0);
        tick();
        check("midrst_no_tail", {31'd0, pkt_sent_o}, 32'd0);
        check("midrst_valid2", {31'd0, flit_valid_o}, 32'd0);

        // Head 0x07 has odd population, so parity is 1 when enabled.
        load_pkt(4'h7, 32'h01020304);
        expect_pkt(4'h7, 32'h01020304, -1, 0);

        // Random packets with occasional stalls.
        for (int n = 0; n < 10; n++) begin
            tick();
            rd   = 4'($urandom_range(0, 15));
            rp   = $urandom;
            sidx = int'($urandom_range(0, 7));
            slen = int'($urandom_range(1, 3));
            load_pkt(rd, rp);
            expect_pkt(rd, rp, sidx, slen);
        end

        check("trk_flags", {31'd0, trk_bad}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
